mem_arbiter: RTL and testbench

Shares the single-port 4 KiB CHIP-8 memory (`mem`) between up to N requesters: CPU, GPU blitter and display scan-out. It round-robins per-requester read/write handshakes onto the one `mem` read port and one write port, and holds each grant until the transaction completes. It returns read data and acks only to the owner. It sits between `mem` and its clients, replacing the CPU-side state-based muxing of the GPU's memory signals.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CHIP-8 memory arbiter: widths, requester ids,
// memory map and the arbiter state encoding.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 8;

    localparam int REQ_CPU  = 0;
    localparam int REQ_GPU  = 1;
    localparam int REQ_SCAN = 2;

    localparam logic [MEM_ADDR_W-1:0] MAP_STACK  = 12'h000;
    localparam logic [MEM_ADDR_W-1:0] MAP_REGS   = 12'h020;
    localparam logic [MEM_ADDR_W-1:0] MAP_SCREEN = 12'h100;

    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } arb_state_e;

    // (a + b) mod n for operands already below n
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index at or above ptr_i,
// wrapping modulo N. Kept generic so other arbiters can reuse it.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] cand;

    // Scan from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'(wrap_add(int'(ptr_i), k, N));
            if (elig_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single CHIP-8 memory between CPU, GPU
// blitter and scan-out; writes complete in the grant cycle, reads hold the grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    localparam int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ*ADDR_W-1:0] req_read_idx,
    output logic [N_REQ-1:0]        req_read_ack,
    output logic [DATA_W-1:0]       req_read_byte,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_write_idx,
    input  logic [N_REQ*DATA_W-1:0] req_write_byte,
    output logic [N_REQ-1:0]        req_write_ack,
    output logic                    mem_read,
    output logic [ADDR_W-1:0]       mem_read_idx,
    input  logic [DATA_W-1:0]       mem_read_byte,
    input  logic                    mem_read_ack,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_write_idx,
    output logic [DATA_W-1:0]       mem_write_byte,
    output logic                    busy,
    output logic [OW-1:0]           owner
);

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     rr_q, rr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

    logic              pick_vld;
    logic [OW-1:0]     pick_idx;
    logic [ADDR_W-1:0] win_rd_idx, win_wr_idx;
    logic [DATA_W-1:0] win_wr_byte;

    rr_picker #(.N(N_REQ), .W(OW)) u_pick (
        .elig_i  (req_read | req_write),
        .ptr_i   (rr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    assign win_rd_idx  = req_read_idx[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign win_wr_idx  = req_write_idx[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign win_wr_byte = req_write_byte[int'(pick_idx)*DATA_W +: DATA_W];

    // Outputs are forced to their idle values while reset is held so a
    // reset landing mid-read cannot leak a strobe or ack.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        owner_d        = owner_q;
        rd_idx_d       = rd_idx_q;
        req_read_ack   = '0;
        req_read_byte  = '0;
        req_write_ack  = '0;
        mem_read       = 1'b0;
        mem_read_idx   = '0;
        mem_write      = 1'b0;
        mem_write_idx  = '0;
        mem_write_byte = '0;
        busy           = 1'b0;
        owner          = '0;
        if (rst_n) begin
            busy  = (state_q == ST_RD_WAIT);
            owner = owner_q;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        owner_d = pick_idx;
                        rr_d    = OW'(wrap_add(int'(pick_idx), 1, N_REQ));
                        // A pending write beats the same requester's read.
                        if (req_write[pick_idx]) begin
                            mem_write              = 1'b1;
                            mem_write_idx          = win_wr_idx;
                            mem_write_byte         = win_wr_byte;
                            req_write_ack[pick_idx] = 1'b1;
                        end else begin
                            mem_read     = 1'b1;
                            mem_read_idx = win_rd_idx;
                            rd_idx_d     = win_rd_idx;
                            state_d      = ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    mem_read     = ~mem_read_ack;
                    mem_read_idx = rd_idx_q;
                    if (mem_read_ack) begin
                        req_read_ack[owner_q] = 1'b1;
                        req_read_byte         = mem_read_byte;
                        state_d               = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            rd_idx_q <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_read, req_write;
    logic [N*AW-1:0] req_read_idx, req_write_idx;
    logic [N*DW-1:0] req_write_byte;
    logic [N-1:0]    req_read_ack, req_write_ack;
    logic [DW-1:0]   req_read_byte;
    logic            mem_read, mem_write, mem_read_ack, busy;
    logic [AW-1:0]   mem_read_idx, mem_write_idx;
    logic [DW-1:0]   mem_read_byte, mem_write_byte;
    logic [1:0]      owner;

    // Memory model: one-cycle read latency, manual ack override for corner cases.
    logic [DW-1:0] mem [0:4095];
    logic          ack_auto_q = 1'b0;
    logic [DW-1:0] byte_auto_q = '0;
    logic          mem_auto, ack_force;
    logic [DW-1:0] byte_force;
    logic          pre_we;
    logic [AW-1:0] pre_idx;
    logic [DW-1:0] pre_data;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [50:0] obs, exp_o;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)    mem[pre_idx] <= pre_data;
        if (mem_write) mem[mem_write_idx] <= mem_write_byte;
        ack_auto_q  <= mem_read;
        byte_auto_q <= mem[mem_read_idx];
    end

    assign mem_read_ack  = mem_auto ? ack_auto_q : ack_force;
    assign mem_read_byte = mem_auto ? byte_auto_q : byte_force;

    assign obs = {busy, mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
                  req_read_ack, req_read_byte, req_write_ack, owner};

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_read_idx(req_read_idx),
        .req_read_ack(req_read_ack), .req_read_byte(req_read_byte),
        .req_write(req_write), .req_write_idx(req_write_idx),
        .req_write_byte(req_write_byte), .req_write_ack(req_write_ack),
        .mem_read(mem_read), .mem_read_idx(mem_read_idx),
        .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack),
        .mem_write(mem_write), .mem_write_idx(mem_write_idx),
        .mem_write_byte(mem_write_byte), .busy(busy), .owner(owner)
    );

    function automatic logic [50:0] ev(input logic bsy, input logic mrd, input logic [11:0] ridx,
                                        input logic mwr, input logic [11:0] widx, input logic [7:0] wbyte,
                                        input logic [2:0] rack, input logic [7:0] rbyte,
                                        input logic [2:0] wack, input logic [1:0] own);
        return {bsy, mrd, ridx, mwr, widx, wbyte, rack, rbyte, wack, own};
    endfunction

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        req_read_idx[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write_idx[i*AW +: AW]  = a;
        req_write_byte[i*DW +: DW] = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_read = '0; req_write = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req_read = 3'b111; req_write = 3'b111;
        set_wr(0, 12'h123, 8'h45); set_rd(1, 12'h456);
        #1;
        exp_o = '0;
        if (obs !== exp_o) begin err_cnt++; $display("FAIL reset_held: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        rst_n = 1'b1; req_read = '0; req_write = '0;
        #1;
        if (obs !== exp_o) begin err_cnt++; $display("FAIL reset_release: got %h expected %h", obs, exp_o); end
        vec_cnt++;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        req_read = 3'b001; set_rd(0, 12'h200);
        #1; exp_o = ev(0, 1, 12'h200, 0, 0, 0, 3'b000, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL single_rd grant: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        #1; exp_o = ev(1, 0, 12'h200, 0, 0, 0, 3'b001, 8'h12, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL single_rd ack: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_read = 3'b000;
        #1; exp_o = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL single_rd idle: got %h expected %h", obs, exp_o); end
        vec_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        req_write = 3'b011; set_wr(0, 12'h020, 8'hAA); set_wr(1, 12'h100, 8'h55);
        req_read = 3'b100; set_rd(2, 12'h1F8);
        #1; exp_o = ev(0, 0, 0, 1, 12'h020, 8'hAA, 0, 0, 3'b001, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL simul c0 cpu_wr: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b010;
        #1; exp_o = ev(0, 0, 0, 1, 12'h100, 8'h55, 0, 0, 3'b010, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL simul c1 gpu_wr: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b000;
        #1; exp_o = ev(0, 1, 12'h1F8, 0, 0, 0, 0, 0, 0, 1);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL simul c2 scan_rd: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        #1; exp_o = ev(1, 0, 12'h1F8, 0, 0, 0, 3'b100, 8'h3C, 0, 2);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL simul c3 scan_ack: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_read = 3'b000;
        #1; exp_o = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL simul c4 idle: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        if (mem[12'h020] !== 8'hAA) begin err_cnt++; $display("FAIL simul mem020: got %h expected aa", mem[12'h020]); end
        vec_cnt++;
        if (mem[12'h100] !== 8'h55) begin err_cnt++; $display("FAIL simul mem100: got %h expected 55", mem[12'h100]); end
        vec_cnt++;
    endtask

    task automatic test_fairness();
        logic [7:0] rd_tbl [3];
        int others [3];
        int exp_w, grants;
        rd_tbl = '{8'h12, 8'h77, 8'h3C};
        others = '{0, 0, 0};
        exp_w = 0; grants = 0;
        do_reset();
        @(negedge clk);
        set_rd(0, 12'h200); set_rd(1, 12'h300); set_rd(2, 12'h1F8);
        req_read = 3'b111;
        for (int cyc = 0; cyc < 1000 && grants < 300; cyc++) begin
            #1;
            if (req_read_ack !== 3'b000) begin
                if ({req_read_ack, req_read_byte} !== {3'(1 << exp_w), rd_tbl[exp_w]}) begin
                    err_cnt++;
                    $display("FAIL fair grant %0d: got ack %b byte %h expected ack %b byte %h",
                             grants, req_read_ack, req_read_byte, 3'(1 << exp_w), rd_tbl[exp_w]);
                end
                vec_cnt++;
                if (others[exp_w] > N - 1) begin
                    err_cnt++;
                    $display("FAIL fair wait req%0d: got %0d other grants expected <= %0d", exp_w, others[exp_w], N - 1);
                end
                vec_cnt++;
                for (int i = 0; i < N; i++) others[i] = (i == exp_w) ? 0 : others[i] + 1;
                exp_w = (exp_w + 1) % N;
                grants++;
            end
            @(negedge clk);
        end
        if (grants < 300) begin err_cnt++; $display("FAIL fair timeout: got %0d grants expected 300", grants); end
        vec_cnt++;
        req_read = 3'b000;
    endtask

    task automatic test_write_blocked();
        do_reset();
        mem_auto = 1'b0; ack_force = 1'b0; byte_force = '0;
        @(negedge clk);
        req_read = 3'b010; set_rd(1, 12'h300);
        #1; exp_o = ev(0, 1, 12'h300, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL wblk c0 gpu_rd: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b001; set_wr(0, 12'h040, 8'h9A);
        #1; exp_o = ev(1, 1, 12'h300, 0, 0, 0, 0, 0, 0, 1);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL wblk c1 held: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        #1;
        if (obs !== exp_o) begin err_cnt++; $display("FAIL wblk c2 held: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        ack_force = 1'b1; byte_force = 8'h77;
        #1; exp_o = ev(1, 0, 12'h300, 0, 0, 0, 3'b010, 8'h77, 0, 1);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL wblk c3 gpu_ack: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        ack_force = 1'b0; req_read = 3'b000;
        #1; exp_o = ev(0, 0, 0, 1, 12'h040, 8'h9A, 0, 0, 3'b001, 1);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL wblk c4 cpu_wr: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b000; mem_auto = 1'b1;
        #1; exp_o = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL wblk c5 idle: got %h expected %h", obs, exp_o); end
        vec_cnt++;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        mem_auto = 1'b0; ack_force = 1'b0; byte_force = '0;
        @(negedge clk);
        req_read = 3'b001; set_rd(0, 12'h200);
        #1; exp_o = ev(0, 1, 12'h200, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c0 grant: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        #1; exp_o = ev(1, 1, 12'h200, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c1 wait: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        rst_n = 1'b0; req_read = 3'b000;
        #1; exp_o = '0;
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c2 in_reset: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c3 release: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        ack_force = 1'b1; byte_force = 8'hEE;
        #1;
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c4 stale_ack: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        ack_force = 1'b0;
        req_write = 3'b011; set_wr(0, 12'h050, 8'hAB); set_wr(1, 12'h060, 8'hCD);
        #1; exp_o = ev(0, 0, 0, 1, 12'h050, 8'hAB, 0, 0, 3'b001, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c5 rr_ptr0: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b010;
        #1; exp_o = ev(0, 0, 0, 1, 12'h060, 8'hCD, 0, 0, 3'b010, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c6 gpu_wr: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b000; mem_auto = 1'b1;
        #1; exp_o = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rstmid c7 idle: got %h expected %h", obs, exp_o); end
        vec_cnt++;
    endtask

    task automatic test_rw_same();
        do_reset();
        @(negedge clk);
        req_write = 3'b001; set_wr(0, 12'h02F, 8'h01);
        req_read = 3'b001; set_rd(0, 12'h02F);
        #1; exp_o = ev(0, 0, 0, 1, 12'h02F, 8'h01, 0, 0, 3'b001, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rw c0 write_first: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_write = 3'b000;
        #1; exp_o = ev(0, 1, 12'h02F, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rw c1 read_grant: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        #1; exp_o = ev(1, 0, 12'h02F, 0, 0, 0, 3'b001, 8'h01, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rw c2 read_data: got %h expected %h", obs, exp_o); end
        vec_cnt++;
        @(negedge clk);
        req_read = 3'b000;
        #1; exp_o = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_o) begin err_cnt++; $display("FAIL rw c3 idle: got %h expected %h", obs, exp_o); end
        vec_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        req_read = '0; req_write = '0;
        req_read_idx = '0; req_write_idx = '0; req_write_byte = '0;
        mem_auto = 1'b1; ack_force = 1'b0; byte_force = '0;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        preload(12'h200, 8'h12);
        preload(12'h1F8, 8'h3C);
        preload(12'h300, 8'h77);
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_write_blocked();
        test_reset_mid_read();
        test_rw_same();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
